// File: rtl/uart_gauss_sequencer.sv
// Streams UART RX bytes through the Gaussian filter, 9 taps per sample, and sends each result on TX; tx_start follows the 9th byte by GAUSS_LAT+3 cycles, and waits while tx_ready is low.
// RX bytes arriving outside RX_WAIT are dropped; define SEQ_TIMEOUT_EN to abort after TIMEOUT_CYCLES idle RX cycles.
module uart_gauss_sequencer #(
    parameter int TAPS           = 9,
    parameter int GAUSS_LAT      = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_we,
    input  logic [1:0]  cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    input  logic        cpu_gauss_we,
    input  logic        cpu_gauss_sel,
    input  logic [31:0] cpu_gauss_din,
    output logic        gauss_we,
    output logic        gauss_sel,
    output logic [31:0] gauss_din,
    input  logic [31:0] gauss_dout,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        tx_ready,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    output logic        busy
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RX_WAIT = 3'd1;
    localparam logic [2:0] S_G_WRITE = 3'd2;
    localparam logic [2:0] S_G_WAIT  = 3'd3;
    localparam logic [2:0] S_G_READ  = 3'd4;
    localparam logic [2:0] S_TX_WAIT = 3'd5;

`ifdef SEQ_TIMEOUT_EN
    localparam logic TO_EN = 1'b1;
`else
    localparam logic TO_EN = 1'b0;
`endif

    logic [2:0]  r_state;
    logic [15:0] r_count;
    logic [15:0] r_remaining;
    logic [3:0]  r_tap;
    logic [7:0]  r_byte;
    logic [7:0]  r_last;
    logic [7:0]  r_lat_cnt;
    logic [31:0] r_to_cnt;
    logic        r_done;
    logic        r_conflict;
    logic        r_timeout;

    logic w_ctrl_wr, w_start, w_abort, w_to_hit, w_busy;
    logic w_start_ok, w_start_zero, w_tx_fire, w_status_wr, w_rx_idle;
    logic w_unused;

    assign w_busy       = (r_state != S_IDLE);
    assign w_ctrl_wr    = cpu_we && (cpu_addr == 2'd0);
    assign w_status_wr  = cpu_we && (cpu_addr == 2'd2);
    assign w_rx_idle    = (r_state == S_RX_WAIT) && !rx_valid;
    assign w_to_hit     = TO_EN && w_rx_idle && (r_to_cnt == 32'(TIMEOUT_CYCLES - 1));
    assign w_abort      = (w_ctrl_wr && cpu_wdata[1]) || w_to_hit;
    assign w_start      = w_ctrl_wr && cpu_wdata[0] && !w_abort && !w_busy;
    assign w_start_ok   = w_start && (r_count != 16'd0);
    assign w_start_zero = w_start && (r_count == 16'd0);
    assign w_tx_fire    = (r_state == S_TX_WAIT) && tx_ready && !w_abort;
    assign w_unused     = ^{cpu_wdata[31:16], gauss_dout[31:8]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_count     <= 16'd0;
            r_remaining <= 16'd0;
            r_tap       <= 4'd0;
            r_byte      <= 8'd0;
            r_last      <= 8'd0;
            r_lat_cnt   <= 8'd0;
            r_to_cnt    <= 32'd0;
            r_done      <= 1'b0;
            r_conflict  <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            // Sticky-flag clear comes first so a same-cycle set still lands
            if (w_status_wr) begin
                r_done     <= 1'b0;
                r_conflict <= 1'b0;
                r_timeout  <= 1'b0;
            end
            if (w_busy && cpu_gauss_we) r_conflict <= 1'b1;
            if (w_to_hit)               r_timeout  <= 1'b1;
            if (cpu_we && (cpu_addr == 2'd1)) r_count <= cpu_wdata[15:0];
            r_to_cnt <= w_rx_idle ? r_to_cnt + 32'd1 : 32'd0;

            if (w_abort) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_start_ok) begin
                            r_remaining <= r_count;
                            r_done      <= 1'b0;
                            r_tap       <= 4'd0;
                            r_state     <= S_RX_WAIT;
                        end else if (w_start_zero) begin
                            r_done <= 1'b1;
                        end
                    end
                    S_RX_WAIT: begin
                        if (rx_valid) begin
                            r_byte  <= rx_data;
                            r_state <= S_G_WRITE;
                        end
                    end
                    S_G_WRITE: begin
                        r_tap     <= r_tap + 4'd1;
                        r_lat_cnt <= 8'd0;
                        r_state   <= (r_tap == 4'(TAPS - 1)) ? S_G_WAIT : S_RX_WAIT;
                    end
                    S_G_WAIT: begin
                        r_lat_cnt <= r_lat_cnt + 8'd1;
                        if (r_lat_cnt == 8'(GAUSS_LAT - 1)) r_state <= S_G_READ;
                    end
                    S_G_READ: begin
                        r_last  <= gauss_dout[7:0];
                        r_state <= S_TX_WAIT;
                    end
                    S_TX_WAIT: begin
                        if (tx_ready) begin
                            r_remaining <= r_remaining - 16'd1;
                            r_tap       <= 4'd0;
                            if (r_remaining == 16'd1) begin
                                r_state <= S_IDLE;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= S_RX_WAIT;
                            end
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign busy      = w_busy;
    assign gauss_we  = w_busy ? (r_state == S_G_WRITE) : cpu_gauss_we;
    assign gauss_sel = w_busy ? ((r_state == S_G_WAIT) || (r_state == S_G_READ)) : cpu_gauss_sel;
    assign gauss_din = w_busy ? {24'd0, r_byte} : cpu_gauss_din;
    assign tx_start  = w_tx_fire;
    assign tx_data   = r_last;

    always_comb begin
        cpu_rdata = 32'd0;
        case (cpu_addr)
            2'd1:    cpu_rdata = {16'd0, r_count};
            2'd2:    cpu_rdata = {r_remaining, 12'd0, r_timeout, r_conflict, r_done, w_busy};
            2'd3:    cpu_rdata = {24'd0, r_last};
            default: cpu_rdata = 32'd0;
        endcase
    end
endmodule

// File: tb/tb_uart_gauss_sequencer.sv
// Randomised bench for uart_gauss_sequencer with a behavioural 3x3 Gaussian filter model and expected-result scoreboard.
module tb_uart_gauss_sequencer;
    localparam int GAUSS_LAT = 4;
`ifdef SEQ_TIMEOUT_EN
    localparam int TO_CYC = 100;
`else
    localparam int TO_CYC = 1000000;
`endif

    logic        clk;
    logic        rst;
    logic        cpu_we;
    logic [1:0]  cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_gauss_we;
    logic        cpu_gauss_sel;
    logic [31:0] cpu_gauss_din;
    logic        gauss_we;
    logic        gauss_sel;
    logic [31:0] gauss_din;
    logic [31:0] gauss_dout;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        tx_ready;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        busy;

    uart_gauss_sequencer #(.TAPS(9), .GAUSS_LAT(GAUSS_LAT), .TIMEOUT_CYCLES(TO_CYC)) dut (
        .clk(clk), .rst(rst),
        .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .cpu_gauss_we(cpu_gauss_we), .cpu_gauss_sel(cpu_gauss_sel), .cpu_gauss_din(cpu_gauss_din),
        .gauss_we(gauss_we), .gauss_sel(gauss_sel), .gauss_din(gauss_din), .gauss_dout(gauss_dout),
        .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_ready(tx_ready), .tx_start(tx_start), .tx_data(tx_data), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] gauss9(input logic [7:0] w[9]);
        int k[9] = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
        int s = 0;
        for (int i = 0; i < 9; i++) s += k[i] * int'(w[i]);
        return 8'(s / 16);
    endfunction

    // Filter model: result appears GAUSS_LAT edges after the 9th data write, garbage before
    logic       f_clr;
    logic [7:0] f_win[9];
    logic [7:0] f_res;
    int         f_n  = 0;
    int         f_cd = 0;
    always @(posedge clk) begin
        if (f_clr) begin
            f_n  = 0;
            f_cd = 0;
        end else begin
            if (f_cd > 0) begin
                f_cd--;
                if (f_cd == 0) gauss_dout <= {24'hA5C3E1, f_res};
            end
            if (gauss_we && !gauss_sel) begin
                f_win[f_n] = gauss_din[7:0];
                if (f_n == 8) begin
                    f_res = gauss9(f_win);
                    f_cd  = GAUSS_LAT;
                    gauss_dout <= {24'h5A3C1E, ~f_res};
                    f_n = 0;
                end else begin
                    f_n++;
                end
            end
        end
    end

    int         tx_cnt     = 0;
    int         tx_cyc     = 0;
    int         tx_bad_rdy = 0;
    int         busy_cnt   = 0;
    logic [7:0] tx_last_dat;
    always @(negedge clk) begin
        if (tx_start) begin
            tx_cnt++;
            tx_cyc      = cyc;
            tx_last_dat = tx_data;
            if (!tx_ready) tx_bad_rdy++;
        end
        if (busy) busy_cnt++;
    end

    int last_rx_cyc = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [1:0] a, input logic [31:0] d);
        cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
        tick();
        cpu_we = 1'b0;
    endtask

    task automatic cpu_read(input logic [1:0] a, output logic [31:0] d);
        cpu_addr = a;
        #1;
        d = cpu_rdata;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data = b; rx_valid = 1'b1; last_rx_cyc = cyc;
        tick();
        rx_valid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic send_sample(input logic fixed, output logic [7:0] exp, input int last_gap);
        logic [7:0] w[9];
        for (int i = 0; i < 9; i++) begin
            w[i] = fixed ? 8'(8'h10 + i) : 8'($urandom_range(0, 255));
            send_byte(w[i], (i == 8) ? last_gap : 1 + $urandom_range(0, 2));
        end
        exp = gauss9(w);
    endtask

    task automatic wait_tx(input int n0, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            tick();
            if (tx_cnt > n0) ok = 1'b1;
        end
    endtask

    task automatic start_run(input logic [15:0] n);
        f_clr = 1'b1; tick(); f_clr = 1'b0;
        cpu_write(2'd1, {16'd0, n});
        cpu_write(2'd0, 32'd1);
    endtask

    task automatic test_reset();
        logic [31:0] d, r;
        d = $urandom;
        rst = 1'b0; f_clr = 1'b1;
        cpu_gauss_we = 1'b1; cpu_gauss_sel = 1'b1; cpu_gauss_din = d;
        repeat (3) tick();
        total++; if (gauss_we !== 1'b1) begin bad++; $display("FAIL reset_gauss_we got=%b want=1", gauss_we); end
        total++; if (gauss_sel !== 1'b1) begin bad++; $display("FAIL reset_gauss_sel got=%b want=1", gauss_sel); end
        total++; if (gauss_din !== d) begin bad++; $display("FAIL reset_gauss_din got=%h want=%h", gauss_din, d); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL reset_tx_start got=%b want=0", tx_start); end
        cpu_read(2'd2, r);
        total++; if (r !== 32'd0) begin bad++; $display("FAIL reset_status got=%h want=0", r); end
        cpu_read(2'd3, r);
        total++; if (r !== 32'd0) begin bad++; $display("FAIL reset_last got=%h want=0", r); end
        cpu_gauss_we = 1'b0; cpu_gauss_sel = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        f_clr = 1'b0;
    endtask

    task automatic test_single();
        logic [7:0] exp;
        logic [31:0] r;
        logic ok;
        int n0;
        tx_ready = 1'b1;
        n0 = tx_cnt;
        start_run(16'd1);
        send_sample(1'b1, exp, 0);
        wait_tx(n0, ok);
        total++; if (!ok) begin bad++; $display("FAIL single_tx_seen got=timeout want=pulse"); end
        total++; if (tx_last_dat !== 8'h14) begin bad++; $display("FAIL single_tx_data got=%h want=14", tx_last_dat); end
        total++; if (tx_cyc - last_rx_cyc !== GAUSS_LAT + 3) begin bad++; $display("FAIL single_latency got=%0d want=%0d", tx_cyc - last_rx_cyc, GAUSS_LAT + 3); end
        repeat (3) tick();
        total++; if (tx_cnt !== n0 + 1) begin bad++; $display("FAIL single_tx_count got=%0d want=%0d", tx_cnt - n0, 1); end
        cpu_read(2'd2, r);
        total++; if (r !== 32'h0000_0002) begin bad++; $display("FAIL single_status got=%h want=00000002", r); end
        cpu_read(2'd3, r);
        total++; if (r !== 32'h0000_0014) begin bad++; $display("FAIL single_last got=%h want=00000014", r); end
    endtask

    task automatic test_multi_backpressure();
        logic [7:0] exp;
        logic [31:0] r;
        logic ok;
        int n0;
        tx_ready = 1'b0;
        start_run(16'd3);
        for (int s = 0; s < 3; s++) begin
            n0 = tx_cnt;
            send_sample(1'b0, exp, 0);
            send_byte(8'($urandom_range(0, 255)), 0);
            repeat (50) tick();
            total++; if (tx_cnt !== n0) begin bad++; $display("FAIL multi_hold%0d got=%0d pulses want=0", s, tx_cnt - n0); end
            cpu_read(2'd2, r);
            total++; if (r[31:16] !== 16'(3 - s)) begin bad++; $display("FAIL multi_rem_pre%0d got=%0d want=%0d", s, r[31:16], 3 - s); end
            tx_ready = 1'b1;
            wait_tx(n0, ok);
            tx_ready = 1'b0;
            total++; if (!ok) begin bad++; $display("FAIL multi_tx_seen%0d got=timeout want=pulse", s); end
            total++; if (tx_last_dat !== exp) begin bad++; $display("FAIL multi_tx_data%0d got=%h want=%h", s, tx_last_dat, exp); end
            cpu_read(2'd2, r);
            total++; if (r[31:16] !== 16'(2 - s)) begin bad++; $display("FAIL multi_rem_post%0d got=%0d want=%0d", s, r[31:16], 2 - s); end
        end
        tick();
        cpu_read(2'd2, r);
        total++; if (r[3:0] !== 4'b0010) begin bad++; $display("FAIL multi_status got=%h want=done only", r[3:0]); end
        total++; if (tx_bad_rdy !== 0) begin bad++; $display("FAIL multi_tx_ready got=%0d pulses without ready want=0", tx_bad_rdy); end
        tx_ready = 1'b1;
    endtask

    task automatic test_conflict();
        logic [7:0] exp;
        logic [31:0] r;
        logic ok;
        int n0;
        f_clr = 1'b1; tick(); f_clr = 1'b0;
        cpu_write(2'd1, 32'd1);
        cpu_we = 1'b1; cpu_addr = 2'd0; cpu_wdata = 32'd1;
        cpu_gauss_we = 1'b1; cpu_gauss_sel = 1'b1; cpu_gauss_din = 32'h77;
        #1;
        total++; if (gauss_we !== 1'b1) begin bad++; $display("FAIL start_cycle_passthru got=%b want=1", gauss_we); end
        tick();
        cpu_we = 1'b0; cpu_gauss_we = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL start_busy got=%b want=1", busy); end
        cpu_read(2'd2, r);
        total++; if (r[2] !== 1'b0) begin bad++; $display("FAIL start_no_conflict got=%b want=0", r[2]); end
        n0 = tx_cnt;
        send_sample(1'b0, exp, 0);
        tick();
        cpu_gauss_we = 1'b1; cpu_gauss_sel = 1'b0; cpu_gauss_din = 32'h99;
        #1;
        total++; if (gauss_we !== 1'b0 || gauss_sel !== 1'b1) begin bad++; $display("FAIL conflict_mux got=we%b/sel%b want=we0/sel1", gauss_we, gauss_sel); end
        tick();
        cpu_gauss_we = 1'b0;
        wait_tx(n0, ok);
        total++; if (!ok || tx_last_dat !== exp) begin bad++; $display("FAIL conflict_tx got=%h ok=%b want=%h", tx_last_dat, ok, exp); end
        tick();
        cpu_read(2'd2, r);
        total++; if (r[3:0] !== 4'b0110) begin bad++; $display("FAIL conflict_flag got=%b want=0110", r[3:0]); end
        cpu_write(2'd2, 32'd0);
        cpu_read(2'd2, r);
        total++; if (r !== 32'd0) begin bad++; $display("FAIL conflict_clear got=%h want=0", r); end
    endtask

    task automatic test_abort_edges();
        logic [31:0] r;
        int n0, b0;
        tx_ready = 1'b1;
        start_run(16'd1);
        for (int i = 0; i < 5; i++) send_byte(8'($urandom_range(0, 255)), 1);
        cpu_write(2'd0, 32'd2);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_idle got=%b want=0", busy); end
        cpu_read(2'd2, r);
        total++; if (r !== 32'h0001_0000) begin bad++; $display("FAIL abort_status got=%h want=00010000", r); end
        n0 = tx_cnt;
        repeat (30) tick();
        total++; if (tx_cnt !== n0) begin bad++; $display("FAIL abort_no_tx got=%0d want=0", tx_cnt - n0); end
        cpu_write(2'd1, 32'd0);
        b0 = busy_cnt;
        cpu_write(2'd0, 32'd1);
        repeat (5) tick();
        total++; if (busy_cnt !== b0) begin bad++; $display("FAIL zero_count_busy got=%0d busy cycles want=0", busy_cnt - b0); end
        cpu_read(2'd2, r);
        total++; if (r[3:0] !== 4'b0010) begin bad++; $display("FAIL zero_count_done got=%b want=0010", r[3:0]); end
        cpu_write(2'd1, 32'd1);
        b0 = busy_cnt;
        cpu_write(2'd0, 32'd3);
        repeat (5) tick();
        total++; if (busy_cnt !== b0) begin bad++; $display("FAIL abort_wins got=%0d busy cycles want=0", busy_cnt - b0); end
        cpu_write(2'd1, 32'd2);
        cpu_write(2'd0, 32'd1);
        cpu_write(2'd1, 32'd7);
        cpu_write(2'd0, 32'd1);
        cpu_read(2'd2, r);
        total++; if (r[31:16] !== 16'd2 || r[0] !== 1'b1) begin bad++; $display("FAIL restart_ignored got=rem%0d busy%b want=rem2 busy1", r[31:16], r[0]); end
        cpu_write(2'd0, 32'd2);
        cpu_write(2'd2, 32'd0);
    endtask

    task automatic test_timeout();
        logic [31:0] r;
        start_run(16'd1);
`ifdef SEQ_TIMEOUT_EN
        repeat (90) tick();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL timeout_early got=%b want=1", busy); end
        repeat (20) tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL timeout_idle got=%b want=0", busy); end
        cpu_read(2'd2, r);
        total++; if (r[3:0] !== 4'b1000) begin bad++; $display("FAIL timeout_flag got=%b want=1000", r[3:0]); end
`else
        repeat (10000) tick();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL no_timeout_busy got=%b want=1", busy); end
        cpu_read(2'd2, r);
        total++; if (r[3] !== 1'b0) begin bad++; $display("FAIL no_timeout_flag got=%b want=0", r[3]); end
`endif
        cpu_write(2'd0, 32'd2);
        cpu_write(2'd2, 32'd0);
    endtask

    initial begin
        rst = 1'b0; f_clr = 1'b1;
        cpu_we = 1'b0; cpu_addr = 2'd0; cpu_wdata = 32'd0;
        cpu_gauss_we = 1'b0; cpu_gauss_sel = 1'b0; cpu_gauss_din = 32'd0;
        gauss_dout = 32'd0; rx_valid = 1'b0; rx_data = 8'd0; tx_ready = 1'b1;
        test_reset();
        test_single();
        test_multi_backpressure();
        test_conflict();
        test_abort_edges();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_gauss_sequencer.md
Name: uart_gauss_sequencer

Overview:
- Autonomous controller that streams pixel bytes from the UART receiver through the Gaussian filter and returns the results on the UART transmitter, without per-byte CPU involvement.
- Sits on the 10 MHz core clock beside the UART and Gaussian filter peripherals.
- Arbitrates the filter's write port between the CPU (memory-mapped path) and its own sequencer.
- CPU configures and monitors it through a 4-word register window.

Parameters:
- TAPS, 9, bytes written to the filter per output sample (3x3 window).
- GAUSS_LAT, 4, cycles from last filter write until the result is valid on gauss_dout.
- TIMEOUT_CYCLES, 1000000, RX idle limit in cycles; used only with SEQ_TIMEOUT_EN.

Ports:
- clk  in  1  core clock (10 MHz)
- rst  in  1  asynchronous, active-low reset
- cpu_we  in  1  CPU write strobe to sequencer window
- cpu_addr  in  2  register select: 0 CTRL, 1 COUNT, 2 STATUS, 3 LAST
- cpu_wdata  in  32  CPU write data
- cpu_rdata  out  32  register read data (combinational on cpu_addr)
- cpu_gauss_we  in  1  CPU write request to filter (from write decoder)
- cpu_gauss_sel  in  1  CPU filter select (0 data-in, 1 result)
- cpu_gauss_din  in  32  CPU filter write data
- gauss_we  out  1  filter write enable
- gauss_sel  out  1  filter select
- gauss_din  out  32  filter write data
- gauss_dout  in  32  filter result
- rx_valid  in  1  one-cycle pulse, new byte received
- rx_data  in  8  received byte
- tx_ready  in  1  transmitter idle
- tx_start  out  1  one-cycle transmit pulse
- tx_data  out  8  byte to transmit
- busy  out  1  sequencer owns the filter

Behaviour:
- Clock and reset: one clock domain (clk). rst low asynchronously forces IDLE; all counters, flags, COUNT and LAST go to 0; tx_start=0, busy=0. Filter mux outputs follow CPU inputs while in IDLE.
- Registers:
  - CTRL (write only): bit0 start, bit1 abort.
  - COUNT[15:0]: number of output samples.
  - STATUS (read): bit0 busy, bit1 done (sticky), bit2 conflict (sticky), bit3 timeout (sticky), [31:16] remaining. Any STATUS write clears bits 1-3.
  - LAST: last transmitted result, zero-extended.
- Start: accepted only in IDLE with COUNT≠0. It loads remaining=COUNT, clears done, and goes to RX_WAIT. Start in IDLE with COUNT=0 sets done immediately, with no busy cycle. Start while busy is ignored.
- FSM:
  - IDLE
  - RX_WAIT: on rx_valid, capture rx_data and go to G_WRITE.
  - G_WRITE: one cycle with gauss_we=1, gauss_sel=0, gauss_din={24'b0,byte}; tap++. If tap==TAPS, go to G_WAIT, else RX_WAIT.
  - G_WAIT: wait exactly GAUSS_LAT cycles with gauss_sel=1, then go to G_READ.
  - G_READ: latch gauss_dout[7:0] into LAST; go to TX_WAIT.
  - TX_WAIT: when tx_ready=1, pulse tx_start for one cycle with tx_data=LAST[7:0]; remaining--; tap=0. If remaining==0, go to IDLE and set done, else RX_WAIT.
- rx_valid outside RX_WAIT: the byte is dropped; no buffering.
- Arbitration:
  - busy=1 in every state except IDLE; gauss_* then come from the sequencer.
  - cpu_gauss_we while busy is dropped and sets conflict.
  - cpu_gauss_we in the same cycle that start is accepted still reaches the filter; busy rises the next cycle.
- Abort: from any state, returns to IDLE next cycle. Abort does not set done; tap and remaining are held for readback until the next start. Abort and start in the same write: abort wins.
- Latency: last tap byte to tx_start = 1 (G_WRITE) + GAUSS_LAT + 1 (G_READ) + 1 cycles, minimum, with tx_ready high.

Optional Feature:
- SEQ_TIMEOUT_EN defined: a counter runs while in RX_WAIT and resets on each rx_valid. When it reaches TIMEOUT_CYCLES, the block behaves as abort and sets timeout.
- Not defined: RX_WAIT waits indefinitely; STATUS bit3 reads 0.

Test Plan:
- Reset: hold rst=0 with cpu_gauss_we=1 → gauss_we=1 passes through, busy=0, tx_start=0, STATUS=0.
- Single sample: COUNT=1, start, send 9 bytes 0x10..0x18, model returns 0x14 → one tx_start with tx_data=0x14 exactly GAUSS_LAT+3 cycles after the 9th byte. STATUS then reads done=1, remaining=0, LAST=0x14.
- Multi-sample with backpressure: COUNT=3, tx_ready held low 50 cycles per sample → 3 tx_start pulses, each only once tx_ready is high; remaining reads 2,1,0.
- Conflict: cpu_gauss_we=1 during G_WAIT → gauss_we remains sequencer-driven (0), conflict=1. A STATUS write of 0 clears it.
- Abort and edges: abort after 5 of 9 bytes → IDLE next cycle, no tx_start, remaining=1. Start with COUNT=0 → done=1, busy never asserts.
- SEQ_TIMEOUT_EN with TIMEOUT_CYCLES=100: start, send no bytes → IDLE at cycle 100, timeout=1. Without the macro, still busy at cycle 10000.
